core_lsu: RTL and testbench

Load/store unit sitting directly downstream of core_alu in the RV32I core. It takes the ALU-computed effective address (RESULT), the store data (RS2) and the one-hot load/store decode strobes. It then runs one data-memory transaction over a req/gnt/rvalid bus, aligns byte lanes, and sign- or zero-extends load data for register writeback. It is a single-outstanding, multi-cycle unit; the pipeline stalls while o_ready is low.

---
 rtl/core_lsu.sv | 234 +++++++++++++++++++++++
 tb/tb_core_lsu.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : core_lsu
//  Description : RV32I load/store unit. Issues one data-memory transaction
//                over a req/gnt/rvalid bus, generates byte enables, replicates
//                store data across lanes and extends load data for writeback.
//                Misaligned accesses and bus timeouts raise an exception.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_lsu #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [7:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [4:0]  i_rd,
    output logic        o_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        o_done,
    output logic        o_wb_en,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_exc,
    output logic [1:0]  o_exc_code,
    output logic [31:0] o_bad_addr
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_FIN  = 2'd3;

    // Access size encoding
    localparam logic [1:0] c_SZ_B = 2'd0;
    localparam logic [1:0] c_SZ_H = 2'd1;
    localparam logic [1:0] c_SZ_W = 2'd2;

    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;

    // Latched transaction context
    logic            r_is_load;
    logic [1:0]      r_size;
    logic            r_uns;
    logic [31:0]     r_addr;
    logic [4:0]      r_rd;
    logic            r_we;
    logic [3:0]      r_be;
    logic [31:0]     r_wdata;
    logic            r_exc;
    logic [1:0]      r_exc_code;
    logic [31:0]     r_bad_addr;
    logic [TO_W-1:0] r_to_cnt;
    logic [4:0]      r_wb_rd;
    logic [31:0]     r_wb_data;

    // Decode of the incoming op
    logic            w_is_load;
    logic [1:0]      w_size;
    logic            w_uns;
    logic            w_misalign;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;

    logic            w_accept;
    logic            w_to_hit;
    logic            w_rsp;
    logic            w_timeout;
    logic [31:0]     w_lane;
    logic [31:0]     w_ext;

    // Priority decode of the one-hot op: LW > LH > LHU > LB > LBU > SW > SH > SB
    always_comb begin
        w_is_load = 1'b0;
        w_size    = c_SZ_B;
        w_uns     = 1'b0;
        if (i_op[2]) begin
            w_is_load = 1'b1;
            w_size    = c_SZ_W;
        end else if (i_op[1]) begin
            w_is_load = 1'b1;
            w_size    = c_SZ_H;
        end else if (i_op[4]) begin
            w_is_load = 1'b1;
            w_size    = c_SZ_H;
            w_uns     = 1'b1;
        end else if (i_op[0]) begin
            w_is_load = 1'b1;
        end else if (i_op[3]) begin
            w_is_load = 1'b1;
            w_uns     = 1'b1;
        end else if (i_op[7]) begin
            w_size    = c_SZ_W;
        end else if (i_op[6]) begin
            w_size    = c_SZ_H;
        end
        w_misalign = ((w_size == c_SZ_H) && i_addr[0]) ||
                     ((w_size == c_SZ_W) && (i_addr[1:0] != 2'b00));
        case (w_size)
            c_SZ_B: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            c_SZ_H: begin
                w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = i_wdata;
            end
        endcase
    end

    assign w_accept  = i_valid && (r_state == c_IDLE) && (|i_op);
    assign w_to_hit  = (r_to_cnt >= c_TO_LAST);
    assign w_rsp     = (r_state == c_WAIT) && mem_rvalid;
    // A grant or response arriving in the last allowed cycle still wins
    assign w_timeout = ((r_state == c_REQ)  && !mem_gnt    && w_to_hit) ||
                       ((r_state == c_WAIT) && !mem_rvalid && w_to_hit);

    // Select the addressed lane of the response and extend it
    always_comb begin
        w_lane = mem_rdata >> {r_addr[1:0], 3'b000};
        case (r_size)
            c_SZ_B:  w_ext = r_uns ? {24'd0, w_lane[7:0]}
                                   : {{24{w_lane[7]}}, w_lane[7:0]};
            c_SZ_H:  w_ext = r_uns ? {16'd0, w_lane[15:0]}
                                   : {{16{w_lane[15]}}, w_lane[15:0]};
            default: w_ext = w_lane;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: if (w_accept) w_state_nxt = w_misalign ? c_FIN : c_REQ;
            c_REQ: begin
                if (mem_gnt)        w_state_nxt = c_WAIT;
                else if (w_to_hit)  w_state_nxt = c_FIN;
            end
            c_WAIT: begin
                if (mem_rvalid)     w_state_nxt = c_FIN;
                else if (w_to_hit)  w_state_nxt = c_FIN;
            end
            default:                w_state_nxt = c_IDLE;
        endcase
    end

    // Outputs decoded from state and latched context
    always_comb begin
        o_ready    = (r_state == c_IDLE);
        mem_req    = (r_state == c_REQ);
        o_done     = (r_state == c_FIN);
        o_wb_en    = (r_state == c_FIN) && r_is_load && !r_exc;
        o_exc      = (r_state == c_FIN) && r_exc;
        mem_we     = r_we;
        mem_addr   = {r_addr[31:2], 2'b00};
        mem_be     = r_be;
        mem_wdata  = r_wdata;
        o_exc_code = r_exc_code;
        o_bad_addr = r_bad_addr;
        o_wb_rd    = r_wb_rd;
        o_wb_data  = r_wb_data;
    end

    // Transaction context, timeout counter, exception and writeback registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_load  <= 1'b0;
            r_size     <= c_SZ_B;
            r_uns      <= 1'b0;
            r_addr     <= 32'd0;
            r_rd       <= 5'd0;
            r_we       <= 1'b0;
            r_be       <= 4'd0;
            r_wdata    <= 32'd0;
            r_exc      <= 1'b0;
            r_exc_code <= 2'b00;
            r_bad_addr <= 32'd0;
            r_to_cnt   <= '0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'd0;
        end else begin
            if (w_accept) begin
                r_is_load  <= w_is_load;
                r_size     <= w_size;
                r_uns      <= w_uns;
                r_addr     <= i_addr;
                r_rd       <= i_rd;
                r_we       <= !w_is_load;
                r_be       <= w_be;
                r_wdata    <= w_wdata;
                r_to_cnt   <= '0;
                r_exc      <= w_misalign;
                r_exc_code <= w_misalign ? (w_is_load ? 2'b01 : 2'b10) : 2'b00;
                if (w_misalign) r_bad_addr <= i_addr;
            end else if ((r_state == c_REQ) || (r_state == c_WAIT)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_exc      <= 1'b1;
                r_exc_code <= 2'b11;
                r_bad_addr <= r_addr;
            end
            if (w_rsp && r_is_load) begin
                r_wb_data <= w_ext;
                r_wb_rd   <= r_rd;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_lsu
//  Description : Self-checking bench for core_lsu with a bus responder and
//                scoreboards for bus requests and completions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_lsu;

    localparam logic [7:0] c_OP_LB  = 8'h01;
    localparam logic [7:0] c_OP_LH  = 8'h02;
    localparam logic [7:0] c_OP_LW  = 8'h04;
    localparam logic [7:0] c_OP_LBU = 8'h08;
    localparam logic [7:0] c_OP_LHU = 8'h10;
    localparam logic [7:0] c_OP_SB  = 8'h20;
    localparam logic [7:0] c_OP_SH  = 8'h40;
    localparam logic [7:0] c_OP_SW  = 8'h80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [7:0]  i_op = 8'd0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_wdata = 32'd0;
    logic [4:0]  i_rd = 5'd0;
    logic        o_ready, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        o_done, o_wb_en, o_exc;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data, o_bad_addr;
    logic [1:0]  o_exc_code;

    always #5 clk = ~clk;

    core_lsu #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_op(i_op), .i_addr(i_addr),
        .i_wdata(i_wdata), .i_rd(i_rd), .o_ready(o_ready), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .o_done(o_done), .o_wb_en(o_wb_en), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
        .o_exc(o_exc), .o_exc_code(o_exc_code), .o_bad_addr(o_bad_addr)
    );

    typedef struct {
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
        logic [1:0]  code;
        logic [31:0] bad;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    exp_t exp_q[$];
    req_t req_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;

    // Responder controls
    int          gnt_delay = 0;
    bit          no_gnt = 1'b0;
    bit          no_rsp = 1'b0;
    bit          inject_rvalid = 1'b0;
    bit          rsp_pend = 1'b0;
    logic [31:0] rdata_v = 32'd0;
    int          req_cnt = 0;
    int          req_total = 0;
    int          last_req_len = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus responder: grant after gnt_delay request cycles, respond next cycle
    always @(negedge clk) begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (rst) begin
            rsp_pend = 1'b0;
            req_cnt  = 0;
        end else if (inject_rvalid) begin
            mem_rvalid    = 1'b1;
            mem_rdata     = 32'hBAD0BAD0;
            inject_rvalid = 1'b0;
        end else if (rsp_pend) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata_v;
            rsp_pend   = 1'b0;
        end else if (mem_req) begin
            req_total++;
            if (!no_gnt && req_cnt == gnt_delay) begin
                mem_gnt      = 1'b1;
                last_req_len = req_cnt + 1;
                req_cnt      = 0;
                rsp_pend     = !no_rsp;
                if (req_q.size() == 0) begin
                    check_val("req_unexpected", 32'd1, 32'd0);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    check_val("req_we",    {31'd0, mem_we}, {31'd0, r.we});
                    check_val("req_addr",  mem_addr, r.addr);
                    check_val("req_be",    {28'd0, mem_be}, {28'd0, r.be});
                    if (r.we) check_val("req_wdata", mem_wdata, r.wdata);
                end
            end else begin
                req_cnt++;
            end
        end else begin
            req_cnt = 0;
        end
    end

    // Completion monitor
    always @(negedge clk) begin
        if (!rst && o_done) begin
            done_cnt++;
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_val("done_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_val("wb_en", {31'd0, o_wb_en}, {31'd0, e.wb_en});
                check_val("exc",   {31'd0, o_exc},   {31'd0, e.exc});
                if (e.wb_en) begin
                    check_val("wb_rd",   {27'd0, o_wb_rd}, {27'd0, e.rd});
                    check_val("wb_data", o_wb_data, e.data);
                end
                if (e.exc) begin
                    check_val("exc_code", {30'd0, o_exc_code}, {30'd0, e.code});
                    check_val("bad_addr", o_bad_addr, e.bad);
                end
            end
        end
    end

    // Reference model: push expected request and completion for one op
    task automatic model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] rdat, input bit tmo);
        bit ld, uns, mis;
        int sz;
        exp_t e;
        req_t r;
        logic [31:0] b;
        logic [15:0] h;
        ld = 1'b1; uns = 1'b0; sz = 0;
        if      (op[2]) sz = 2;
        else if (op[1]) sz = 1;
        else if (op[4]) begin sz = 1; uns = 1'b1; end
        else if (op[0]) sz = 0;
        else if (op[3]) uns = 1'b1;
        else if (op[7]) begin ld = 1'b0; sz = 2; end
        else if (op[6]) begin ld = 1'b0; sz = 1; end
        else            ld = 1'b0;
        mis = (sz == 2 && a[1:0] != 2'b00) || (sz == 1 && a[0]);
        e.wb_en = ld && !mis && !tmo;
        e.rd = rd; e.exc = mis || tmo; e.bad = a;
        e.code = tmo ? 2'b11 : (ld ? 2'b01 : 2'b10);
        b = rdat >> (8 * a[1:0]);
        h = a[1] ? rdat[31:16] : rdat[15:0];
        if (sz == 0)      e.data = uns ? {24'd0, b[7:0]} : {{24{b[7]}}, b[7:0]};
        else if (sz == 1) e.data = uns ? {16'd0, h} : {{16{h[15]}}, h};
        else              e.data = rdat;
        r.we = !ld; r.addr = {a[31:2], 2'b00};
        if (sz == 0)      begin r.be = 4'b0001 << a[1:0]; r.wdata = {4{wd[7:0]}}; end
        else if (sz == 1) begin r.be = a[1] ? 4'b1100 : 4'b0011; r.wdata = {2{wd[15:0]}}; end
        else              begin r.be = 4'b1111; r.wdata = wd; end
        if (!mis && !tmo) req_q.push_back(r);
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd);
        @(negedge clk);
        check_val("ready_before_issue", {31'd0, o_ready}, 32'd1);
        i_valid = 1'b1; i_op = op; i_addr = a; i_wdata = wd; i_rd = rd;
        acc_cyc = cyc;
        @(negedge clk);
        i_valid = 1'b0; i_op = 8'd0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdat,
                          input int exp_lat, input bit tmo);
        int start;
        rdata_v = rdat;
        model(op, a, wd, rd, rdat, tmo);
        start = done_cnt;
        issue(op, a, wd, rd);
        for (int i = 0; i < 200 && done_cnt == start; i++) @(posedge clk);
        if (done_cnt == start) check_val({tag, "_done_timeout"}, 32'd0, 32'd1);
        else check_val({tag, "_latency"}, 32'(last_done_cyc - acc_cyc), 32'(exp_lat));
    endtask

    initial begin
        int rt;
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int start, rt;
        repeat (3) @(negedge clk);
        check_val("rst_ready",    {31'd0, o_ready}, 32'd1);
        check_val("rst_mem_req",  {31'd0, mem_req}, 32'd0);
        check_val("rst_done",     {31'd0, o_done},  32'd0);
        check_val("rst_be",       {28'd0, mem_be},  32'd0);
        check_val("rst_wb_data",  o_wb_data,        32'd0);
        check_val("rst_bad_addr", o_bad_addr,       32'd0);
        check_val("rst_exc_code", {30'd0, o_exc_code}, 32'd0);
        rst = 1'b0;

        run_op("lw",  c_OP_LW,  32'h100, 32'd0, 5'd5, 32'hDEADBEEF, 3, 1'b0);
        run_op("lb",  c_OP_LB,  32'h203, 32'd0, 5'd6, 32'h80FF1234, 3, 1'b0);
        run_op("lbu", c_OP_LBU, 32'h203, 32'd0, 5'd7, 32'h80FF1234, 3, 1'b0);

        gnt_delay = 2;
        run_op("sh",  c_OP_SH,  32'h302, 32'h0000ABCD, 5'd0, 32'd0, 5, 1'b0);
        check_val("sh_req_cycles", 32'(last_req_len), 32'd3);
        check_val("sh_wb_hold",    o_wb_data, 32'h00000080);
        check_val("sh_wb_rd_hold", {27'd0, o_wb_rd}, 32'd7);
        gnt_delay = 0;

        rt = req_total;
        run_op("lw_mis",  c_OP_LW,  32'h101, 32'd0, 5'd1, 32'd0, 1, 1'b0);
        run_op("sh_mis",  c_OP_SH,  32'h301, 32'h1111, 5'd0, 32'd0, 1, 1'b0);
        run_op("lhu_mis", c_OP_LHU, 32'h103, 32'd0, 5'd2, 32'd0, 1, 1'b0);
        check_val("mis_no_req", 32'(req_total - rt), 32'd0);

        run_op("lh",  c_OP_LH,  32'h102, 32'd0, 5'd8,  32'h80017FFF, 3, 1'b0);
        run_op("lhu", c_OP_LHU, 32'h100, 32'd0, 5'd9,  32'h80017FFF, 3, 1'b0);
        run_op("sb",  c_OP_SB,  32'h101, 32'h12345678, 5'd0, 32'd0, 3, 1'b0);
        run_op("sw",  c_OP_SW,  32'h400, 32'hCAFEF00D, 5'd0, 32'd0, 3, 1'b0);
        run_op("prio", c_OP_LW | c_OP_SB, 32'h104, 32'h55, 5'd10, 32'h11223344, 3, 1'b0);

        // Bus timeout: no grant ever
        no_gnt = 1'b1;
        run_op("sw_tmo", c_OP_SW, 32'h500, 32'h1, 5'd0, 32'd0, 17, 1'b1);
        no_gnt = 1'b0;
        start = done_cnt;
        @(posedge clk);
        inject_rvalid = 1'b1;
        repeat (4) @(negedge clk);
        check_val("late_rvalid_ignored", 32'(done_cnt - start), 32'd0);
        check_val("tmo_ready_back", {31'd0, o_ready}, 32'd1);

        // Valid with empty op is ignored
        rt = req_total;
        @(negedge clk);
        i_valid = 1'b1; i_op = 8'd0; i_addr = 32'h700;
        @(negedge clk);
        i_valid = 1'b0;
        check_val("zero_op_ready", {31'd0, o_ready}, 32'd1);
        repeat (2) @(negedge clk);
        check_val("zero_op_no_req", 32'(req_total - rt), 32'd0);

        // Reset while waiting for the response
        no_rsp = 1'b1;
        model(c_OP_LW, 32'h600, 32'd0, 5'd3, 32'd0, 1'b0);
        issue(c_OP_LW, 32'h600, 32'd0, 5'd3);
        @(negedge clk);
        check_val("wait_req_low", {31'd0, mem_req}, 32'd0);
        check_val("wait_busy",    {31'd0, o_ready}, 32'd0);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_val("mid_rst_ready",   {31'd0, o_ready}, 32'd1);
        check_val("mid_rst_req",     {31'd0, mem_req}, 32'd0);
        check_val("mid_rst_addr",    mem_addr, 32'd0);
        check_val("mid_rst_wb_data", o_wb_data, 32'd0);
        check_val("mid_rst_we",      {31'd0, mem_we}, 32'd0);
        rst = 1'b0;
        no_rsp = 1'b0;
        run_op("lw_after_rst", c_OP_LW, 32'h800, 32'd0, 5'd4, 32'h0BADF00D, 3, 1'b0);

        repeat (2) @(negedge clk);
        check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check_val("req_q_empty", 32'(req_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
